// File: rtl/reset_seq_pkg.sv
// Shared types and limits for the reset sequencer: the FSM state encoding,
// parameter range limits and the counter-width helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int HOLD_MIN   = 1;
  localparam int GAP_MIN    = 1;
  localparam int DIV_MIN    = 1;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_clk_en_div.sv
// Clock-enable divider: one-cycle ClkEn pulse every DIV cycles, restarting
// from zero whenever Clear is high. Only instantiated under RST_SEQ_CLKDIV_EN.
module clk_en_div
  import reset_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Clear,
  output logic ClkEn
);

  localparam int CNT_W = cnt_width(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             en_q;

  always_ff @(posedge Clk) begin
    if (Clear) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q  <= (cnt_q == CNT_LAST);
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign ClkEn = en_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all channels in reset for HOLD_CYCLES, then releases
// them in order every STAGE_GAP cycles. Define RST_SEQ_CLKDIV_EN for a divided ClkEn.
//
// state    | meaning
// ST_HOLD  | all channels asserted, counting hold cycles
// ST_STAGE | releasing channels one by one, STAGE_GAP apart
// ST_RUN   | every channel released, Ready high
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 1,
  parameter int DIV         = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         SoftReset,
  output logic [NUM_CH-1:0]            ChReset,
  output logic [$clog2(NUM_CH+1)-1:0]  Stage,
  output logic                         Ready,
  output logic                         ClkEn
);

  localparam int STAGE_W = $clog2(NUM_CH + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_CH - 1);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || HOLD_CYCLES < HOLD_MIN ||
      STAGE_GAP < GAP_MIN || DIV < DIV_MIN) begin : g_bad_param
    $error("reset_sequencer: parameter out of range");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [NUM_CH-1:0]   ch_q, ch_d;
  logic                ready_q, ready_d;
  logic                restart;

  assign restart = Reset | SoftReset;

  always_ff @(posedge Clk) begin
    if (restart) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      ch_q    <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      ch_q    <= ch_d;
      ready_q <= ready_d;
    end
  end

  // Ready lags entry into ST_RUN by one edge since it looks at the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    ch_d    = ch_q;
    ready_d = (state_q == ST_RUN);
    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ch_d[0] = 1'b0;
          stage_d = STAGE_W'(1);
          cnt_d   = '0;
          state_d = (NUM_CH == 1) ? ST_RUN : ST_STAGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STAGE: begin
        if (cnt_q == GAP_LAST) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (stage_q == STAGE_W'(i)) ch_d[i] = 1'b0;
          end
          stage_d = stage_q + 1'b1;
          cnt_d   = '0;
          if (stage_q == STAGE_LAST) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        ch_d = '0;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  assign ChReset = ch_q;
  assign Stage   = stage_q;
  assign Ready   = ready_q;

`ifdef RST_SEQ_CLKDIV_EN
  // Clear also on the restart inputs so ClkEn is low on the edge after a reset.
  logic div_clear;
  assign div_clear = ch_q[0] | restart;

  clk_en_div #(
    .DIV (DIV)
  ) u_clk_en_div (
    .Clk   (Clk),
    .Clear (div_clear),
    .ClkEn (ClkEn)
  );
`else
  assign ClkEn = ~ch_q[0];
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, mid-sequence Reset, SoftReset
// in run, combined reset, ClkEn timing and a single-channel instance.
module tb_reset_sequencer;

  logic       Clk;
  logic       Reset;
  logic       SoftReset;
  logic [2:0] ch_reset;
  logic [1:0] stage;
  logic       ready;
  logic       clk_en;
  logic [0:0] ch_reset1;
  logic [0:0] stage1;
  logic       ready1;
  logic       clk_en1;

  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer #(
    .NUM_CH(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .DIV(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .SoftReset(SoftReset),
    .ChReset(ch_reset), .Stage(stage), .Ready(ready), .ClkEn(clk_en)
  );

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(1), .STAGE_GAP(2), .DIV(4)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .SoftReset(SoftReset),
    .ChReset(ch_reset1), .Stage(stage1), .Ready(ready1), .ClkEn(clk_en1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected outputs after edge E(n), n = 0..19, main instance.
  int exp_ch    [20] = '{7,7,7,7,6,6,4,4,0,0,0,0,0,0,0,0,0,0,0,0};
  int exp_stage [20] = '{0,0,0,0,1,1,2,2,3,3,3,3,3,3,3,3,3,3,3,3};
  int exp_ready [20] = '{0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,1,1};
`ifdef RST_SEQ_CLKDIV_EN
  int exp_en    [20] = '{0,0,0,0,0,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0};
  int exp_en1   [8]  = '{0,0,0,0,0,1,0,0};
`else
  int exp_en    [20] = '{0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
  int exp_en1   [8]  = '{0,1,1,1,1,1,1,1};
`endif
  int exp_ch1    [8] = '{1,0,0,0,0,0,0,0};
  int exp_stage1 [8] = '{0,1,1,1,1,1,1,1};
  int exp_ready1 [8] = '{0,0,1,1,1,1,1,1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ch"},    32'(ch_reset), 32'd7);
    check({tag, " stage"}, 32'(stage),    32'd0);
    check({tag, " ready"}, 32'(ready),    32'd0);
    check({tag, " clken"}, 32'(clk_en),   32'd0);
  endtask

  task automatic run_seq(input string name, input int n_last);
    for (int n = 0; n <= n_last; n++) begin
      step();
      check($sformatf("%s E%0d ch", name, n),    32'(ch_reset), 32'(exp_ch[n]));
      check($sformatf("%s E%0d stage", name, n), 32'(stage),    32'(exp_stage[n]));
      check($sformatf("%s E%0d ready", name, n), 32'(ready),    32'(exp_ready[n]));
      check($sformatf("%s E%0d clken", name, n), 32'(clk_en),   32'(exp_en[n]));
    end
  endtask

  initial begin
    Reset     = 1'b1;
    SoftReset = 1'b0;

    // Power-up: four reset edges, then the full release.
    for (int i = 0; i < 4; i++) begin
      step();
      check_reset_vals($sformatf("pwr rst%0d", i));
    end
    Reset = 1'b0;
    run_seq("pwr", 11);

    // Mid-sequence Reset sampled at E5.
    Reset = 1'b1;
    step();
    check_reset_vals("mid rst");
    Reset = 1'b0;
    run_seq("mid", 4);
    Reset = 1'b1;
    step();
    check_reset_vals("mid rst E5");
    Reset = 1'b0;
    run_seq("mid restart", 19);

    // SoftReset for one cycle at E20 while in ST_RUN.
    SoftReset = 1'b1;
    step();
    check_reset_vals("soft E20");
    SoftReset = 1'b0;
    run_seq("soft", 11);

    // SoftReset held three edges: counter must not advance meanwhile.
    SoftReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_vals($sformatf("soft hold%0d", i));
    end
    SoftReset = 1'b0;
    run_seq("soft held", 9);

    // Reset and SoftReset together for two edges, main and single-channel instance.
    Reset     = 1'b1;
    SoftReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_reset_vals($sformatf("both rst%0d", i));
      check($sformatf("one rst%0d ch", i), 32'(ch_reset1), 32'd1);
      check($sformatf("one rst%0d rdy", i), 32'(ready1), 32'd0);
    end
    Reset     = 1'b0;
    SoftReset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      check($sformatf("both E%0d ch", n),    32'(ch_reset), 32'(exp_ch[n]));
      check($sformatf("both E%0d stage", n), 32'(stage),    32'(exp_stage[n]));
      check($sformatf("both E%0d ready", n), 32'(ready),    32'(exp_ready[n]));
      check($sformatf("both E%0d clken", n), 32'(clk_en),   32'(exp_en[n]));
      check($sformatf("one E%0d ch", n),     32'(ch_reset1), 32'(exp_ch1[n]));
      check($sformatf("one E%0d stage", n),  32'(stage1),    32'(exp_stage1[n]));
      check($sformatf("one E%0d ready", n),  32'(ready1),    32'(exp_ready1[n]));
      check($sformatf("one E%0d clken", n),  32'(clk_en1),   32'(exp_en1[n]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
